// File: rtl/dequant_stream_pkg.sv
// Shared types and the shift/round/saturate helper for the NPU dequantizer
// and requantizer datapaths.
package dequant_stream_pkg;

   localparam int DQ_INPUT_WIDTH = 8;
   localparam int DQ_SCALE_WIDTH = 16;
   localparam int DQ_SHIFT_WIDTH = 5;

   // Table entry layout is fixed here; the top-level width parameters default to these values.
   typedef struct packed {
      logic signed [DQ_SCALE_WIDTH-1:0] scale;
      logic signed [DQ_INPUT_WIDTH-1:0] zp;
      logic        [DQ_SHIFT_WIDTH-1:0] shift;
   } dq_param_t;

   typedef struct packed {
      logic               sat;
      logic signed [63:0] val;
   } dq_rs_t;

   // Round half toward +inf, arithmetic right shift, then clamp to out_w signed bits.
   function automatic dq_rs_t dq_round_sat(input logic signed [63:0] p,
                                           input logic        [7:0]  shift,
                                           input int                 out_w);
      logic signed [64:0] wide;
      logic signed [64:0] r;
      logic signed [64:0] hi;
      logic signed [64:0] lo;
      dq_rs_t             res;
      wide = 65'(p);
      if (shift != 8'd0) begin
         r = (wide + (65'sd1 <<< (shift - 8'd1))) >>> shift;
      end else begin
         r = wide;
      end
      hi = (65'sd1 <<< (out_w - 1)) - 65'sd1;
      lo = -(65'sd1 <<< (out_w - 1));
      if (r > hi) begin
         res.sat = 1'b1;
         res.val = hi[63:0];
      end else if (r < lo) begin
         res.sat = 1'b1;
         res.val = lo[63:0];
      end else begin
         res.sat = 1'b0;
         res.val = r[63:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/dequant_stream_lane.sv
// One lane of the dequant datapath: S1 subtract zero point, S2 multiply by scale,
// S3 round/saturate. Stage enables come from the shared valid chain in the top.
module dequant_lane
   import dequant_stream_pkg::*;
#(
   parameter int INPUT_WIDTH  = DQ_INPUT_WIDTH,
   parameter int SCALE_WIDTH  = DQ_SCALE_WIDTH,
   parameter int SHIFT_WIDTH  = DQ_SHIFT_WIDTH,
   parameter int OUTPUT_WIDTH = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en1,
   input  logic                           en2,
   input  logic                           en3,
   input  logic signed [INPUT_WIDTH-1:0]  x,
   input  dq_param_t                      prm,
   output logic signed [OUTPUT_WIDTH-1:0] y,
   output logic                           sat
);

   localparam int DW = INPUT_WIDTH + 1;
   localparam int PW = INPUT_WIDTH + SCALE_WIDTH + 1;

   logic signed [DW-1:0]          d;
   logic signed [SCALE_WIDTH-1:0] scale1;
   logic        [SHIFT_WIDTH-1:0] shift1;
   logic        [SHIFT_WIDTH-1:0] shift2;
   logic signed [PW-1:0]          p;
   dq_rs_t                        rs;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d      <= '0;
         scale1 <= '0;
         shift1 <= '0;
      end else if (en1) begin
         d      <= DW'(x) - DW'(prm.zp);
         scale1 <= prm.scale;
         shift1 <= prm.shift;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p      <= '0;
         shift2 <= '0;
      end else if (en2) begin
         p      <= PW'(d) * PW'(scale1);
         shift2 <= shift1;
      end
   end

   always_comb begin
      rs  = dq_round_sat(64'(p), 8'(shift2), OUTPUT_WIDTH);
      sat = rs.sat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         y <= '0;
      end else if (en3) begin
         y <= OUTPUT_WIDTH'(rs.val);
      end
   end

endmodule

// File: rtl/dequant_stream.sv
// Multi-lane streaming dequantizer: per-channel parameter table, group counter,
// three-stage valid/ready pipeline and sticky saturation flag.
module dequant_stream
   import dequant_stream_pkg::*;
#(
   parameter int INPUT_WIDTH  = DQ_INPUT_WIDTH,
   parameter int OUTPUT_WIDTH = 32,
   parameter int SCALE_WIDTH  = DQ_SCALE_WIDTH,
   parameter int SHIFT_WIDTH  = DQ_SHIFT_WIDTH,
   parameter int NUM_CHANNELS = 64,
   parameter int LANES        = 4
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   per_channel,
   input  logic                                   start,
   input  logic [$clog2(NUM_CHANNELS/LANES):0]    cfg_num_groups,
   input  logic                                   cfg_we,
   input  logic [$clog2(NUM_CHANNELS)-1:0]        cfg_addr,
   input  logic signed [SCALE_WIDTH-1:0]          cfg_scale,
   input  logic signed [INPUT_WIDTH-1:0]          cfg_zp,
   input  logic [SHIFT_WIDTH-1:0]                 cfg_shift,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [LANES*INPUT_WIDTH-1:0]           in_data,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [LANES*OUTPUT_WIDTH-1:0]          out_data,
   output logic                                   sat_flag
);

   localparam int GW = $clog2(NUM_CHANNELS / LANES) + 1;
   localparam int CW = $clog2(NUM_CHANNELS);

   dq_param_t        tbl [NUM_CHANNELS];
   dq_param_t        prm [LANES];
   logic [CW-1:0]    idx [LANES];
   logic [GW-1:0]    grp, grp_use, grp_inc, grp_wrap, ng_eff;
   logic             v1, v2;
   logic             adv1, adv2, adv3, accept;
   logic             en2, en3;
   logic [LANES-1:0] lane_sat;

   // Backpressure chain: a stage may load when empty or when its successor moves on.
   always_comb begin
      adv3     = !out_valid || out_ready;
      adv2     = !v2 || adv3;
      adv1     = !v1 || adv2;
      in_ready = adv1;
      accept   = in_valid && adv1;
      en2      = adv2 && v1;
      en3      = adv3 && v2;
   end

   // A start in the acceptance cycle makes that beat group 0.
   always_comb begin
      grp_use  = start ? '0 : grp;
      ng_eff   = (cfg_num_groups == '0) ? GW'(1) : cfg_num_groups;
      grp_inc  = grp_use + GW'(1);
      grp_wrap = (grp_inc >= ng_eff) ? '0 : grp_inc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grp <= '0;
      end else if (accept) begin
         grp <= grp_wrap;
      end else if (start) begin
         grp <= '0;
      end
   end

   // Entries are sampled at acceptance, so a same-cycle write only affects later beats.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_CHANNELS; k++) begin
            tbl[k] <= '0;
         end
      end else if (cfg_we) begin
         tbl[cfg_addr] <= {cfg_scale, cfg_zp, cfg_shift};
      end
   end

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         if (per_channel) begin
            idx[i] = CW'(32'(grp_use) * LANES + i);
         end else begin
            idx[i] = '0;
         end
         prm[i] = tbl[idx[i]];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (adv1) v1        <= accept;
         if (adv2) v2        <= v1;
         if (adv3) out_valid <= v2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_flag <= 1'b0;
      end else if (start) begin
         sat_flag <= 1'b0;
      end else if (en3 && (|lane_sat)) begin
         sat_flag <= 1'b1;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      dequant_lane #(
         .INPUT_WIDTH (INPUT_WIDTH),
         .SCALE_WIDTH (SCALE_WIDTH),
         .SHIFT_WIDTH (SHIFT_WIDTH),
         .OUTPUT_WIDTH(OUTPUT_WIDTH)
      ) u_lane (
         .clk (clk),
         .rst (rst),
         .en1 (accept),
         .en2 (en2),
         .en3 (en3),
         .x   (in_data[i*INPUT_WIDTH +: INPUT_WIDTH]),
         .prm (prm[i]),
         .y   (out_data[i*OUTPUT_WIDTH +: OUTPUT_WIDTH]),
         .sat (lane_sat[i])
      );
   end

endmodule

// File: tb/tb_dequant_stream.sv
// Self-checking bench for dequant_stream (16-bit output build so saturation is reachable):
// vector table, per-channel wrap, same-cycle config, backpressure and mid-stream reset.
module tb_dequant_stream;

   localparam int OW = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        per_channel, start, cfg_we, in_valid;
   logic [4:0]  cfg_num_groups;
   logic [5:0]  cfg_addr;
   logic [15:0] cfg_scale;
   logic [7:0]  cfg_zp;
   logic [4:0]  cfg_shift;
   logic [31:0] in_data;
   logic        in_ready, out_valid, sat_flag;
   logic        out_ready = 1'b1;
   logic [63:0] out_data;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q[$];
   logic [15:0] m_scale [64];
   logic [7:0]  m_zp    [64];
   logic [4:0]  m_shift [64];
   logic        bp_mode = 1'b0;
   int          hold    = 0;
   logic        hold_prev = 1'b0;
   logic [63:0] prev_data = 64'd0;

   typedef struct packed {
      logic [31:0] xin;
      logic [7:0]  zp;
      logic [15:0] scale;
      logic [4:0]  shift;
      logic [63:0] exp;
      logic        sat;
   } vec_t;
   vec_t vecs [6];

   always #5 clk = ~clk;

   dequant_stream #(.OUTPUT_WIDTH(OW)) dut (
      .clk(clk), .rst(rst), .per_channel(per_channel), .start(start),
      .cfg_num_groups(cfg_num_groups), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_scale(cfg_scale), .cfg_zp(cfg_zp), .cfg_shift(cfg_shift),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sat_flag(sat_flag)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_tests++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   function automatic logic [15:0] model_lane(input logic signed [7:0] x, input logic signed [7:0] zp,
                                              input logic signed [15:0] sc, input logic [4:0] sh);
      longint d, p, r;
      d = x - zp;
      p = d * sc;
      if (sh != 5'd0) r = (p + (64'sd1 <<< (sh - 5'd1))) >>> sh;
      else            r = p;
      if (r > 64'sd32767)       return 16'h7fff;
      else if (r < -64'sd32768) return 16'h8000;
      else                      return r[15:0];
   endfunction

   function automatic logic [63:0] model_beat(input logic [31:0] data);
      logic [63:0] res;
      for (int i = 0; i < 4; i++)
         res[i*16 +: 16] = model_lane(data[i*8 +: 8], m_zp[0], m_scale[0], m_shift[0]);
      return res;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input int addr, input logic [15:0] sc, input logic [7:0] zp, input logic [4:0] sh);
      cfg_we = 1'b1; cfg_addr = 6'(addr); cfg_scale = sc; cfg_zp = zp; cfg_shift = sh;
      tick();
      cfg_we = 1'b0;
      m_scale[addr] = sc; m_zp[addr] = zp; m_shift[addr] = sh;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Called just after a rising edge; in_ready is sampled on the falling edge.
   task automatic send_beat(input logic [31:0] data, input logic st, input logic [63:0] expv);
      int guard = 0;
      in_valid = 1'b1; in_data = data; start = st;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         guard++;
         if (guard > 50) begin
            check("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0; start = 1'b0;
            return;
         end
      end
      @(posedge clk);
      exp_q.push_back(expv);
      #1;
      in_valid = 1'b0; start = 1'b0;
   endtask

   task automatic wait_drain();
      int k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 200) begin
         tick();
         k++;
      end
      check("drain", 64'(exp_q.size()), 64'd0);
   endtask

   always @(posedge clk) begin
      #1;
      if (!bp_mode) out_ready = 1'b1;
      else if (hold > 0) begin out_ready = 1'b0; hold--; end
      else if ($urandom_range(0, 5) == 0) begin out_ready = 1'b0; hold = 2; end
      else out_ready = ~out_ready;
   end

   // Scoreboard and stall-stability monitor.
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", out_data, prev_data);
         end
         if (!in_ready) check("in_ready_only_when_full", 64'(out_valid && !out_ready), 64'd1);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_output: got %h expected no beat", out_data);
            end else begin
               check("out_data", out_data, exp_q.pop_front());
            end
         end
         hold_prev = out_valid && !out_ready;
         prev_data = out_data;
      end
   end

   initial begin
      logic [31:0] d;
      per_channel = 1'b0; start = 1'b0; cfg_we = 1'b0; in_valid = 1'b0;
      cfg_num_groups = 5'd1; cfg_addr = 6'd0; cfg_scale = 16'd0; cfg_zp = 8'd0;
      cfg_shift = 5'd0; in_data = 32'd0;
      for (int i = 0; i < 64; i++) begin m_scale[i] = 16'd0; m_zp[i] = 8'd0; m_shift[i] = 5'd0; end

      vecs[0] = '{xin:32'h007F_8005, zp:8'hFE, scale:16'd3,     shift:5'd0, exp:64'h0006_0183_FE86_0015, sat:1'b0};
      vecs[1] = '{xin:32'hF9FA_0506, zp:8'h00, scale:16'd1,     shift:5'd2, exp:64'hFFFE_FFFF_0001_0002, sat:1'b0};
      vecs[2] = '{xin:32'h7F7F_7F7F, zp:8'h80, scale:16'h7FFF,  shift:5'd0, exp:64'h7FFF_7FFF_7FFF_7FFF, sat:1'b1};
      vecs[3] = '{xin:32'h8080_8080, zp:8'h7F, scale:16'h7FFF,  shift:5'd0, exp:64'h8000_8000_8000_8000, sat:1'b1};
      vecs[4] = '{xin:32'hFF01_9C64, zp:8'h00, scale:16'h03E8,  shift:5'd4, exp:64'hFFC2_003F_E796_186A, sat:1'b0};
      vecs[5] = '{xin:32'h0100_807F, zp:8'h00, scale:16'h8000,  shift:5'd8, exp:64'hFF80_0000_4000_C080, sat:1'b0};

      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", out_data, 64'd0);
      check("rst_sat_flag", 64'(sat_flag), 64'd0);
      rst = 1'b0;
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);

      foreach (vecs[v]) begin
         cfg_write(0, vecs[v].scale, vecs[v].zp, vecs[v].shift);
         pulse_start();
         send_beat(vecs[v].xin, 1'b0, vecs[v].exp);
         wait_drain();
         check("sat_flag", 64'(sat_flag), 64'(vecs[v].sat));
         if (vecs[v].sat) begin
            pulse_start();
            check("sat_flag_clear", 64'(sat_flag), 64'd0);
         end
      end

      // Config write in the acceptance cycle must not reach that beat.
      cfg_write(0, 16'd2, 8'd0, 5'd0);
      cfg_we = 1'b1; cfg_addr = 6'd0; cfg_scale = 16'd5; cfg_zp = 8'd0; cfg_shift = 5'd0;
      send_beat(32'h0403_0201, 1'b0, 64'h0008_0006_0004_0002);
      cfg_we = 1'b0;
      send_beat(32'h0403_0201, 1'b0, 64'h0014_000F_000A_0005);
      wait_drain();

      for (int n = 0; n < 8; n++) cfg_write(n, 16'(n + 1), 8'd0, 5'd0);
      cfg_num_groups = 5'd2; per_channel = 1'b1;
      pulse_start();
      send_beat(32'h0101_0101, 1'b0, 64'h0004_0003_0002_0001);
      send_beat(32'h0101_0101, 1'b0, 64'h0008_0007_0006_0005);
      send_beat(32'h0101_0101, 1'b0, 64'h0004_0003_0002_0001);
      send_beat(32'h0101_0101, 1'b1, 64'h0004_0003_0002_0001);
      send_beat(32'h0101_0101, 1'b0, 64'h0008_0007_0006_0005);
      cfg_num_groups = 5'd0;
      pulse_start();
      send_beat(32'h0101_0101, 1'b0, 64'h0004_0003_0002_0001);
      send_beat(32'h0101_0101, 1'b0, 64'h0004_0003_0002_0001);
      wait_drain();
      per_channel = 1'b0;

      cfg_write(0, 16'hFFB3, 8'd3, 5'd3);
      bp_mode = 1'b1;
      for (int b = 0; b < 10; b++) begin
         d = $urandom;
         send_beat(d, 1'b0, model_beat(d));
      end
      wait_drain();
      bp_mode = 1'b0;
      tick();

      cfg_write(0, 16'd4, 8'd0, 5'd0);
      for (int b = 0; b < 3; b++) begin
         d = $urandom;
         send_beat(d, 1'b0, model_beat(d));
      end
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_out_data", out_data, 64'd0);
      exp_q.delete();
      for (int i = 0; i < 64; i++) begin m_scale[i] = 16'd0; m_zp[i] = 8'd0; m_shift[i] = 5'd0; end
      tick();
      rst = 1'b0;
      tick();
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      repeat (5) tick();
      check("midrst_no_stale", 64'(out_valid), 64'd0);
      send_beat(32'h7F7F_7F7F, 1'b0, 64'd0);
      wait_drain();
      check("midrst_sat_flag", 64'(sat_flag), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
